// File: rtl/val2_pkg.sv
// ---------------------------------------------------------------------------
// val2_pkg
// Shared types and constants for the EXE-stage Val2 shift sequencer.
//   WIDTH     : operand width (only 32 is supported)
//   MAX_STEPS : longest shift sequence (register LSL/LSR by 33 or more)
//   CNT_W     : width of the step counter, enough to hold MAX_STEPS
//   shift_kind_e : ARM shifter kinds, encoded as instruction bits [6:5]
//   state_e      : sequencer FSM states
// ---------------------------------------------------------------------------
package val2_pkg;

  localparam int WIDTH     = 32;
  localparam int MAX_STEPS = 33;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_kind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/val2_step.sv
// ---------------------------------------------------------------------------
// val2_step
// Combinational single-bit shift/rotate of {acc, cy}.
// Ports:
//   kind     in  2      shift kind (LSL/LSR/ASR/ROR)
//   acc      in  WIDTH  current accumulator
//   cy       in  1      current carry
//   acc_next out WIDTH  accumulator after one step
//   cy_next  out 1      carry after one step (the bit shifted out)
// ---------------------------------------------------------------------------
module val2_step #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       kind,
  input  logic [WIDTH-1:0] acc,
  input  logic             cy,
  output logic [WIDTH-1:0] acc_next,
  output logic             cy_next
);
  import val2_pkg::*;

  // One-bit step; the carry is always the bit that leaves the word.
  always_comb begin
    acc_next = acc;
    cy_next  = cy;
    case (kind)
      LSL: begin
        cy_next  = acc[WIDTH-1];
        acc_next = {acc[WIDTH-2:0], 1'b0};
      end
      LSR: begin
        cy_next  = acc[0];
        acc_next = {1'b0, acc[WIDTH-1:1]};
      end
      ASR: begin
        cy_next  = acc[0];
        acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      end
      ROR: begin
        cy_next  = acc[0];
        acc_next = {acc[0], acc[WIDTH-1:1]};
      end
      default: begin
        acc_next = acc;
        cy_next  = cy;
      end
    endcase
  end

endmodule

// File: rtl/val2_seq_ctrl.sv
// ---------------------------------------------------------------------------
// val2_seq_ctrl
// Multi-cycle Val2 sequencer: resolves the shift amount of one operand
// request, then steps a one-bit shifter once per cycle, producing Val2 and
// the shifter carry-out.
// Ports:
//   clk           in  1   clock, rising edge
//   rst           in  1   asynchronous active-low reset
//   start         in  1   request valid, accepted while ready=1
//   ready         out 1   high when not shifting
//   val_rm        in  32  Rm value
//   val_rs        in  8   Rs[7:0], register shift amount
//   shift_operand in  12  instruction bits [11:0]
//   imm           in  1   rotated 8-bit immediate form
//   type_signal   in  1   memory offset form (sign-extended 12 bits)
//   reg_shift     in  1   shift amount taken from val_rs
//   c_in          in  1   current C flag
//   busy          out 1   high while shifting
//   done          out 1   one-cycle pulse, result valid
//   out           out 32  Val2, stable from done until next acceptance
//   c_out         out 1   shifter carry-out, held like out
// ---------------------------------------------------------------------------
module val2_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [7:0]       val_rs,
  input  logic [11:0]      shift_operand,
  input  logic             imm,
  input  logic             type_signal,
  input  logic             reg_shift,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             c_out
);
  import val2_pkg::*;

  state_e           state_r, state_nxt_s;
  logic [WIDTH-1:0] acc_r, ld_acc_s, step_acc_s;
  logic             cy_r, ld_cy_s, step_cy_s;
  logic [CNT_W-1:0] cnt_r, ld_cnt_s;
  logic [1:0]       kind_r, ld_kind_s;
  logic             load_s, step_s;
  logic [4:0]       amt_s;

  assign amt_s = shift_operand[11:7];

  // Resolve initial accumulator, carry, kind and step count for a request.
  always_comb begin
    ld_acc_s  = val_rm;
    ld_cy_s   = c_in;
    ld_cnt_s  = {CNT_W{1'b0}};
    ld_kind_s = shift_operand[6:5];
    if (type_signal) begin
      ld_acc_s  = {{(WIDTH-12){shift_operand[11]}}, shift_operand};
      ld_kind_s = LSL;
    end else if (imm) begin
      // Rotate amount is twice the 4-bit field, always a ROR.
      ld_acc_s  = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
      ld_kind_s = ROR;
      ld_cnt_s  = {1'b0, shift_operand[11:8], 1'b0};
    end else if (reg_shift) begin
      if (val_rs == 8'd0) begin
        ld_cnt_s = {CNT_W{1'b0}};
      end else begin
        case (shift_operand[6:5])
          LSL, LSR: begin
            // 33 steps fully clears the word and the carry.
            ld_cnt_s = (val_rs > 8'd33) ? 6'd33 : val_rs[5:0];
          end
          ASR: begin
            // Beyond 32 the result is pure sign fill.
            ld_cnt_s = (val_rs > 8'd32) ? 6'd32 : val_rs[5:0];
          end
          ROR: begin
            if (val_rs[4:0] == 5'd0) begin
              // Multiple of 32: value unchanged, carry is the top bit.
              ld_cy_s  = val_rm[WIDTH-1];
              ld_cnt_s = {CNT_W{1'b0}};
            end else begin
              ld_cnt_s = {1'b0, val_rs[4:0]};
            end
          end
          default: ld_cnt_s = {CNT_W{1'b0}};
        endcase
      end
    end else begin
      if (amt_s == 5'd0) begin
        case (shift_operand[6:5])
          LSL:      ld_cnt_s = {CNT_W{1'b0}};
          LSR, ASR: ld_cnt_s = 6'd32;  // #0 encodes a shift of 32
          ROR: begin
            // RRX: rotate through carry by one, done at load time.
            ld_acc_s = {c_in, val_rm[WIDTH-1:1]};
            ld_cy_s  = val_rm[0];
            ld_cnt_s = {CNT_W{1'b0}};
          end
          default:  ld_cnt_s = {CNT_W{1'b0}};
        endcase
      end else begin
        ld_cnt_s = {1'b0, amt_s};
      end
    end
  end

  // Next-state logic and load/step strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = (ld_cnt_s != {CNT_W{1'b0}}) ? SHIFT : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        step_s = 1'b1;
        if (cnt_r == 6'd1) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accumulator, carry, step count and latched kind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r  <= {WIDTH{1'b0}};
      cy_r   <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      kind_r <= 2'b00;
    end else if (load_s) begin
      acc_r  <= ld_acc_s;
      cy_r   <= ld_cy_s;
      cnt_r  <= ld_cnt_s;
      kind_r <= ld_kind_s;
    end else if (step_s) begin
      acc_r  <= step_acc_s;
      cy_r   <= step_cy_s;
      cnt_r  <= cnt_r - 6'd1;
    end else begin
      acc_r  <= acc_r;
      cy_r   <= cy_r;
      cnt_r  <= cnt_r;
      kind_r <= kind_r;
    end
  end

  val2_step #(.WIDTH(WIDTH)) u_step (
    .kind     (kind_r),
    .acc      (acc_r),
    .cy       (cy_r),
    .acc_next (step_acc_s),
    .cy_next  (step_cy_s)
  );

  assign ready = (state_r != SHIFT);
  assign busy  = (state_r == SHIFT);
  assign done  = (state_r == DONE);
  assign out   = acc_r;
  assign c_out = cy_r;

endmodule

// File: tb/tb_val2_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_val2_seq_ctrl
// Directed plus randomized bench for val2_seq_ctrl. Expected Val2, carry and
// latency come from a word-level model of the ARM shifter rules.
// ---------------------------------------------------------------------------
module tb_val2_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, imm, type_signal, reg_shift, c_in;
  logic [31:0] val_rm;
  logic [7:0]  val_rs;
  logic [11:0] shift_operand;
  logic        ready, busy, done, c_out;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  val2_seq_ctrl #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ready         (ready),
    .val_rm        (val_rm),
    .val_rs        (val_rs),
    .shift_operand (shift_operand),
    .imm           (imm),
    .type_signal   (type_signal),
    .reg_shift     (reg_shift),
    .c_in          (c_in),
    .busy          (busy),
    .done          (done),
    .out           (out),
    .c_out         (c_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input int k);
    if (k == 0) return v;
    return (v >> k) | (v << (32 - k));
  endfunction

  // Word-level shifter: result, carry and number of shift cycles.
  task automatic model(input logic ts, input logic im, input logic rsh, input logic ci,
                       input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] sh,
                       output logic [31:0] r, output logic c, output int n);
    logic [63:0] t;
    int a;
    int kind;
    kind = int'(sh[6:5]);
    r = rm; c = ci; n = 0;
    if (ts) begin
      r = {{20{sh[11]}}, sh};
    end else if (im) begin
      a = 2 * int'(sh[11:8]);
      r = ror32({24'd0, sh[7:0]}, a);
      c = (a == 0) ? ci : r[31];
      n = a;
    end else begin
      if (rsh) a = int'(rs);
      else     a = int'(sh[11:7]);
      if (!rsh && a == 0 && (kind == 1 || kind == 2)) a = 32;
      if (a == 0) begin
        if (!rsh && kind == 3) begin
          r = {ci, rm[31:1]}; c = rm[0];
        end
      end else begin
        case (kind)
          0: begin
            t = {32'd0, rm} << a; r = t[31:0]; c = t[32];
            n = (a > 33) ? 33 : a;
          end
          1: begin
            t = {rm, 32'd0} >> a; r = t[63:32]; c = t[31];
            n = (a > 33) ? 33 : a;
          end
          2: begin
            t = $signed({rm, 32'd0}) >>> a; r = t[63:32]; c = t[31];
            n = (a > 32) ? 32 : a;
          end
          default: begin
            n = a % 32;
            r = ror32(rm, n);
            c = r[31];
          end
        endcase
      end
    end
  endtask

  // Issue one request from IDLE/DONE (called #1 after an edge) and check it.
  // Returns #1 after the edge on which done rose.
  task automatic run_tx(input logic ts, input logic im, input logic rsh, input logic ci,
                        input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] sh,
                        input bit pulse,
                        output logic [31:0] o, output logic co, output int lat);
    logic [31:0] er;
    logic        ec;
    int          en;
    model(ts, im, rsh, ci, rm, rs, sh, er, ec, en);
    type_signal = ts; imm = im; reg_shift = rsh; c_in = ci;
    val_rm = rm; val_rs = rs; shift_operand = sh;
    chk("ready_before_accept", {31'd0, ready}, 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (en > 0) begin
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      chk("ready_low_in_shift", {31'd0, ready}, 32'd0);
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (pulse && k == 2) begin
        start = 1'b1; val_rm = $urandom; shift_operand = 12'($urandom);
      end
      if (pulse && k == 3) start = 1'b0;
      @(posedge clk); #1;
    end
    if (lat < 0) lat = 99;
    chk("latency", lat, en + 1);
    chk("out", out, er);
    chk("c_out", {31'd0, c_out}, {31'd0, ec});
    chk("ready_in_done", {31'd0, ready}, 32'd1);
    o = out; co = c_out;
  endtask

  // One idle cycle: done drops and the result is held.
  task automatic idle_cycle();
    logic [31:0] ho;
    logic        hc;
    ho = out; hc = c_out;
    @(posedge clk); #1;
    chk("idle_done_low", {31'd0, done}, 32'd0);
    chk("idle_out_held", out, ho);
    chk("idle_c_held", {31'd0, c_out}, {31'd0, hc});
  endtask

  logic [31:0] o;
  logic        co;
  int          lat;
  int          mode;
  logic [7:0]  rs;

  initial begin
    rst = 1'b1; start = 1'b0; imm = 1'b0; type_signal = 1'b0; reg_shift = 1'b0;
    c_in = 1'b0; val_rm = 32'd0; val_rs = 8'd0; shift_operand = 12'd0;
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_out",   out,            32'd0);
    chk("rst_c_out", {31'd0, c_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Offset form.
    run_tx(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 8'd0, 12'h800, 1'b0, o, co, lat);
    chk("tp_offset_out", o, 32'hFFFF_F800);
    chk("tp_offset_c", {31'd0, co}, 32'd1);
    chk("tp_offset_lat", lat, 32'd1);
    idle_cycle();

    // Rotated immediate 0xFF ror 8.
    run_tx(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'd0, 12'h4FF, 1'b0, o, co, lat);
    chk("tp_imm_out", o, 32'hFF00_0000);
    chk("tp_imm_c", {31'd0, co}, 32'd1);
    chk("tp_imm_lat", lat, 32'd9);

    // RRX, back-to-back from DONE.
    run_tx(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 8'd0, 12'h060, 1'b0, o, co, lat);
    chk("tp_rrx_out", o, 32'h8000_0001);
    chk("tp_rrx_c", {31'd0, co}, 32'd1);
    chk("tp_rrx_lat", lat, 32'd1);

    // Register LSR by 40.
    run_tx(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 8'd40, 12'h020, 1'b0, o, co, lat);
    chk("tp_lsr40_out", o, 32'h0);
    chk("tp_lsr40_c", {31'd0, co}, 32'd0);
    chk("tp_lsr40_lat", lat, 32'd34);

    // Register ROR by 32.
    run_tx(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 8'd32, 12'h060, 1'b0, o, co, lat);
    chk("tp_ror32_out", o, 32'h8000_0000);
    chk("tp_ror32_c", {31'd0, co}, 32'd1);
    chk("tp_ror32_lat", lat, 32'd1);
    idle_cycle();

    // Immediate ASR #0 with a stray start pulse mid-shift.
    run_tx(1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 8'd0, 12'h040, 1'b1, o, co, lat);
    chk("tp_asr0_out", o, 32'hFFFF_FFFF);
    chk("tp_asr0_c", {31'd0, co}, 32'd1);
    chk("tp_asr0_lat", lat, 32'd33);
    idle_cycle();

    // Reset in the middle of a 20-step immediate LSL.
    type_signal = 1'b0; imm = 1'b0; reg_shift = 1'b0; c_in = 1'b1;
    val_rm = 32'hDEAD_BEEF; shift_operand = 12'hA00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_busy",  {31'd0, busy},  32'd0);
    chk("mid_rst_done",  {31'd0, done},  32'd0);
    chk("mid_rst_out",   out,            32'd0);
    chk("mid_rst_c_out", {31'd0, c_out}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_no_done", {31'd0, done}, 32'd0);
    run_tx(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'd0, 12'hA00, 1'b0, o, co, lat);
    chk("post_rst_lat", lat, 32'd21);

    // Randomized requests, mixing back-to-back and idle gaps.
    for (int i = 0; i < 150; i++) begin
      mode = $urandom_range(0, 3);
      rs = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      run_tx(mode == 0, mode == 1, mode == 2, 1'($urandom), $urandom, rs,
             12'($urandom), 1'b0, o, co, lat);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/val2_seq_ctrl.md
# val2_seq_ctrl

Multi-cycle sequencer for the EXE-stage second-operand shifter. It accepts one operand request under a start/ready handshake, resolves the shift or rotate amount (immediate rotate, immediate shift, or register-specified shift from Rs[7:0]), then steps a one-bit shift/rotate datapath once per cycle. It produces Val2 plus the ARM shifter carry-out for the ALU and the status-register path. The hazard/stall logic holds the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request valid; accepted when `ready`=1.
- `ready`  out  1  high when not in SHIFT.
- `val_rm`  in  32  Rm value.
- `val_rs`  in  8  Rs[7:0], the register shift amount.
- `shift_operand`  in  12  instruction [11:0].
- `imm`  in  1  32-bit rotated-immediate form.
- `type_signal`  in  1  memory offset form (sign-extend 12 bits).
- `reg_shift`  in  1  shift amount comes from `val_rs`.
- `c_in`  in  1  current C flag.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle pulse when the result is valid.
- `out`  out  32  Val2; held stable from `done` until the next acceptance.
- `c_out`  out  1  shifter carry-out; held like `out`.

## Operation
- Operand select priority: `type_signal` > `imm` > `reg_shift` > immediate shift.
- On acceptance, latch all inputs, then load the accumulator `acc`, carry `cy` and step count `N`.
- Offset form: `acc` = sign-extended `shift_operand`, `cy`=`c_in`, N=0.
- Immediate form:
  - `acc` = {24'b0, sh[7:0]}, ROR kind, N = 2*sh[11:8].
  - If N=0, then `cy`=`c_in`.
- Immediate shift (kind = sh[6:5]: 0 LSL, 1 LSR, 2 ASR, 3 ROR; amt = sh[11:7]):
  - LSL #0: `acc`=rm, `cy`=`c_in`, N=0.
  - LSR #0 and ASR #0 mean a shift of 32, so N=32.
  - ROR #0 is RRX: `acc`={c_in, rm[31:1]}, `cy`=rm[0], N=0.
  - Otherwise N=amt.
- Register shift (n = val_rs):
  - n=0: `acc`=rm, `cy`=`c_in`, N=0.
  - LSL/LSR: N = min(n,33). Shifting 33 yields 0 with carry 0.
  - ASR: N = min(n,32).
  - ROR: N = n[4:0]. If n≠0 and n[4:0]=0, then `acc`=rm, `cy`=rm[31], N=0.
- One step per SHIFT cycle:
  - LSL: `cy`=acc[31], acc<<=1.
  - LSR: `cy`=acc[0], acc>>=1.
  - ASR: `cy`=acc[0], arithmetic shift right by 1.
  - ROR: acc={acc[0],acc[31:1]}, `cy`=acc[0].
- FSM states: IDLE, SHIFT, DONE.
  - IDLE or DONE with `start`=1: load, then go to SHIFT if N>0, else DONE.
  - IDLE or DONE with no start: DONE goes to IDLE.
  - SHIFT: step, decrement count; at count 1 go to DONE.
- `done` = (state==DONE). `out`/`c_out` are driven from the `acc`/`cy` registers.
- `start` during SHIFT is ignored. It is not queued; the requester keeps it asserted.

## Timing
- Reset (asynchronous, active-low): state IDLE; `ready`=1, `busy`=0, `done`=0, `out`=0, `c_out`=0, count 0.
- Reset asserted mid-SHIFT aborts immediately to the reset values. No `done` is issued for the aborted request.
- Latency: acceptance edge T gives `done` high during cycle T+1+N.
  - N=0 gives 1 cycle.
  - Maximum is 34 cycles (register LSL/LSR, n≥33).
- Back-to-back: `start` held in DONE is accepted on that same edge. Throughput is one request per N+1 cycles.
- `ready` falls the cycle after accepting a request with N>0 and rises in DONE.

## Structure
- Package `val2_pkg`:
  - shift-kind enum (LSL=2'b00, LSR, ASR, ROR)
  - FSM state enum
  - `WIDTH`
  - constants `MAX_STEPS`=33, `CNT_W`=6
- Sub-module `val2_step`: combinational single-bit shift/rotate of {`acc`, `cy`} by kind. It is instantiated once in the controller.

## Test plan
- Offset form, sh=12'h800, `type_signal`=1 → `done` 1 cycle after accept, `out`=32'hFFFF_F800, `c_out`=`c_in`.
- Immediate form, sh=12'h4FF (imm 0xFF, rotate 4, N=8) → `done` at T+9, `out`=32'hFF00_0000, `c_out`=1.
- Immediate ROR #0 (RRX), rm=32'h0000_0003, `c_in`=1 → `out`=32'h8000_0001, `c_out`=1, latency 1.
- Register LSR with n=40, rm=32'hFFFF_FFFF → `out`=0, `c_out`=0, `done` at T+34; register ROR with n=32, rm=32'h8000_0000 → `out`=rm, `c_out`=1, latency 1.
- Immediate ASR #0, rm=32'h8000_0000 → `out`=32'hFFFF_FFFF, `c_out`=1, `done` at T+33; a `start` pulse mid-SHIFT is ignored.
- Assert `rst` low at T+5 of a 20-step request → all outputs reset immediately; no `done`; the next request is accepted normally after release.
